// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port 0 is the CPU
// MEM stage, port 1 the debug/loader. Each access runs IDLE -> ACCESS -> DONE.
module dmem_arbiter #(
    parameter int W          = 32,
    parameter int ADDR_BITS  = 18,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    input  logic         m0_we,
    input  logic [W-1:0] m0_addr,
    input  logic [W-1:0] m0_wdata,
    output logic         m0_ack,
    output logic         m0_err,
    output logic [W-1:0] m0_rdata,
    input  logic         m1_req,
    input  logic         m1_we,
    input  logic [W-1:0] m1_addr,
    input  logic [W-1:0] m1_wdata,
    output logic         m1_ack,
    output logic         m1_err,
    output logic [W-1:0] m1_rdata,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic [W-1:0] mem_wen,
    output logic [W-1:0] mem_ren,
    input  logic [W-1:0] mem_rdata,
    output logic         busy,
    output logic         gnt_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [W-1:0] mem_addr_reg, mem_addr_next;
    logic [W-1:0] mem_wdata_reg, mem_wdata_next;
    logic         wen_reg, wen_next;
    logic         ren_reg, ren_next;
    logic         we_reg, we_next;
    logic         err_pending_reg, err_pending_next;
    logic         gnt_reg, gnt_next;
    logic         last_winner_reg, last_winner_next;
    logic         busy_reg, busy_next;
    logic [1:0]   ack_reg, ack_next;
    logic [1:0]   err_reg, err_next;
    logic [1:0]   capture;

    logic [1:0]   req;
    logic         winner;
    logic [W-1:0] sel_addr;
    logic [W-1:0] sel_wdata;
    logic         sel_we;
    logic         addr_err;

    assign req = {m1_req, m0_req};

    // Tie-break: round-robin favours the port that did not win last time.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_winner_reg;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    assign sel_addr  = winner ? m1_addr  : m0_addr;
    assign sel_wdata = winner ? m1_wdata : m0_wdata;
    assign sel_we    = winner ? m1_we    : m0_we;
    assign addr_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> ADDR_BITS) != '0);

    always_comb begin
        state_next       = state_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        wen_next         = 1'b0;
        ren_next         = 1'b0;
        we_next          = we_reg;
        err_pending_next = err_pending_reg;
        gnt_next         = gnt_reg;
        last_winner_next = last_winner_reg;
        busy_next        = busy_reg;
        ack_next         = 2'b00;
        err_next         = 2'b00;
        capture          = 2'b00;
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (|req) begin
                    mem_addr_next    = sel_addr;
                    mem_wdata_next   = sel_wdata;
                    we_next          = sel_we;
                    err_pending_next = addr_err;
                    gnt_next         = winner;
                    last_winner_next = winner;
                    wen_next         = ~addr_err & sel_we;
                    ren_next         = ~addr_err & ~sel_we;
                    busy_next        = 1'b1;
                    state_next       = ACCESS;
                end
            end
            ACCESS: begin
                ack_next[gnt_reg] = 1'b1;
                err_next[gnt_reg] = err_pending_reg;
                capture[gnt_reg]  = ~we_reg & ~err_pending_reg;
                state_next        = DONE;
            end
            DONE: begin
                // No arbitration here so a still-high req cannot be granted twice.
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            wen_reg         <= 1'b0;
            ren_reg         <= 1'b0;
            we_reg          <= 1'b0;
            err_pending_reg <= 1'b0;
            gnt_reg         <= 1'b0;
            last_winner_reg <= 1'b1;
            busy_reg        <= 1'b0;
            ack_reg         <= 2'b00;
            err_reg         <= 2'b00;
        end else begin
            state_reg       <= state_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            wen_reg         <= wen_next;
            ren_reg         <= ren_next;
            we_reg          <= we_next;
            err_pending_reg <= err_pending_next;
            gnt_reg         <= gnt_next;
            last_winner_reg <= last_winner_next;
            busy_reg        <= busy_next;
            ack_reg         <= ack_next;
            err_reg         <= err_next;
        end
    end

    // Per-port read-data holding registers; only a clean read on that port updates them.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [W-1:0] rdata_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_reg <= '0;
                end else if (capture[gi]) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign m0_ack    = ack_reg[0];
    assign m1_ack    = ack_reg[1];
    assign m0_err    = err_reg[0];
    assign m1_err    = err_reg[1];
    assign m0_rdata  = g_port[0].rdata_reg;
    assign m1_rdata  = g_port[1].rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wen   = {{(W-1){1'b0}}, wen_reg};
    assign mem_ren   = {{(W-1){1'b0}}, ren_reg};
    assign busy      = busy_reg;
    assign gnt_id    = gnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a word memory
// model, plus a fixed-priority instance checked for starvation of port 1.
module tb_dmem_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         m0_req = 1'b0, m0_we = 1'b0;
    logic [W-1:0] m0_addr = '0, m0_wdata = '0;
    logic         m0_ack, m0_err;
    logic [W-1:0] m0_rdata;
    logic         m1_req = 1'b0, m1_we = 1'b0;
    logic [W-1:0] m1_addr = '0, m1_wdata = '0;
    logic         m1_ack, m1_err;
    logic [W-1:0] m1_rdata;
    logic [W-1:0] mem_addr, mem_wdata, mem_wen, mem_ren, mem_rdata;
    logic         busy, gnt_id;

    logic         f_m0_req = 1'b0, f_m1_req = 1'b0;
    logic [W-1:0] f_m0_addr = 32'h10, f_m1_addr = 32'h20;
    logic         f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
    logic [W-1:0] f_m0_rdata, f_m1_rdata;
    logic [W-1:0] f_mem_addr, f_mem_wdata, f_mem_wen, f_mem_ren, f_mem_rdata;
    logic         f_busy, f_gnt_id;

    logic [W-1:0] mem [0:255];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wen[0]) mem[mem_addr[9:2]] <= mem_wdata;
    end

    assign f_mem_rdata = 32'h5A5A_0000 ^ f_mem_addr;

    dmem_arbiter #(.W(W), .ADDR_BITS(18), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    dmem_arbiter #(.W(W), .ADDR_BITS(18), .FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .m0_req(f_m0_req), .m0_we(1'b0), .m0_addr(f_m0_addr), .m0_wdata(32'h0),
        .m0_ack(f_m0_ack), .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_we(1'b0), .m1_addr(f_m1_addr), .m1_wdata(32'h0),
        .m1_ack(f_m1_ack), .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_wen(f_mem_wen),
        .mem_ren(f_mem_ren), .mem_rdata(f_mem_rdata),
        .busy(f_busy), .gnt_id(f_gnt_id)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on one port; wmask bit0 = mem_wen seen in ACCESS, bit1 = seen later.
    task automatic access(input int port, input logic we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, output int lat, output logic err,
                          output logic [W-1:0] rd, output logic [1:0] wmask);
        logic got;
        if (port == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        lat = 0; wmask = 2'b00; got = 1'b0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (mem_wen != '0) wmask[(lat >= 2) ? 1 : 0] = 1'b1;
            got = (port == 0) ? m0_ack : m1_ack;
        end
        err = (port == 0) ? m0_err : m1_err;
        rd  = (port == 0) ? m0_rdata : m1_rdata;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        $display("txn port=%0d we=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
                 port, we, addr, wdata, lat, err, rd);
    endtask

    // Both ports request reads continuously until n acks; grants must alternate from 'first'.
    task automatic rr_run(input int n, input int first);
        int acks = 0;
        int cyc = 0;
        int overlap = 0;
        int longack = 0;
        int port_seen;
        logic p0 = 1'b0;
        logic p1 = 1'b0;
        m0_we = 1'b0; m0_addr = 32'h10; m1_we = 1'b0; m1_addr = 32'h20;
        m0_req = 1'b1; m1_req = 1'b1;
        while (acks < n && cyc < 60) begin
            tick();
            cyc++;
            if (m0_ack && m1_ack) overlap++;
            if ((m0_ack && p0) || (m1_ack && p1)) longack++;
            p0 = m0_ack;
            p1 = m1_ack;
            if (m0_ack || m1_ack) begin
                port_seen = m1_ack ? 1 : 0;
                chk($sformatf("rr_gnt%0d", acks), 32'(gnt_id), (first + acks) % 2);
                chk($sformatf("rr_port%0d", acks), port_seen, (first + acks) % 2);
                $display("txn rr ack port=%0d gnt_id=%0d cycle=%0d", port_seen, gnt_id, cyc);
                acks++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("rr_count", acks, n);
        chk("rr_overlap", overlap, 0);
        chk("rr_longack", longack, 0);
        tick();
        chk("rr_ackclr", 32'({m1_ack, m0_ack}), 0);
    endtask

    initial begin
        int lat;
        logic err;
        logic [W-1:0] rd;
        logic [1:0] wmask;
        int c0, c1, cg, ackcnt;
        logic [W-1:0] addr_hold;

        #3 rst = 1'b0;
        tick();
        tick();
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m0_err", 32'(m0_err), 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_ack", 32'(m1_ack), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_f_busy", 32'(f_busy), 0);
        rst = 1'b1;
        tick();

        // Fixed priority: both requesting for 30 cycles -> acks on port 0 at cycles 2,5,...,29.
        f_m0_req = 1'b1;
        f_m1_req = 1'b1;
        c0 = 0; c1 = 0; cg = 0;
        repeat (30) begin
            tick();
            if (f_m0_ack) c0++;
            if (f_m1_ack) c1++;
            if (f_gnt_id) cg++;
        end
        f_m0_req = 1'b0;
        f_m1_req = 1'b0;
        $display("txn fixed m0_acks=%0d m1_acks=%0d", c0, c1);
        chk("fix_m0_acks", c0, 10);
        chk("fix_m1_acks", c1, 0);
        chk("fix_gnt1_cycles", cg, 0);
        chk("fix_m0_rdata", f_m0_rdata, 32'h5A5A_0010);
        repeat (3) tick();

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, err, rd, wmask);
        chk("wr10_lat", lat, 2);
        chk("wr10_err", 32'(err), 0);
        chk("wr10_wen_access_only", 32'(wmask), 1);
        chk("wr10_mem", mem[4], 32'hDEADBEEF);
        chk("wr10_gnt", 32'(gnt_id), 0);

        access(0, 1'b0, 32'h10, 32'h0, lat, err, rd, wmask);
        chk("rd10_lat", lat, 2);
        chk("rd10_err", 32'(err), 0);
        chk("rd10_rdata", rd, 32'hDEADBEEF);
        chk("rd10_no_wen", 32'(wmask), 0);

        access(1, 1'b1, 32'h12, 32'h12345678, lat, err, rd, wmask);
        chk("mis12_lat", lat, 2);
        chk("mis12_err", 32'(err), 1);
        chk("mis12_no_wen", 32'(wmask), 0);
        chk("mis12_mem10", mem[4], 32'hDEADBEEF);
        chk("mis12_gnt", 32'(gnt_id), 1);

        access(0, 1'b0, 32'h40000, 32'h0, lat, err, rd, wmask);
        chk("oor_err", 32'(err), 1);
        chk("oor_rdata_held", rd, 32'hDEADBEEF);

        access(1, 1'b0, 32'h10, 32'h0, lat, err, rd, wmask);
        chk("m1rd_err", 32'(err), 0);
        chk("m1rd_rdata", rd, 32'hDEADBEEF);

        // Last winner is port 1, so the tie sequence starts with port 0.
        rr_run(4, 0);

        addr_hold = mem_addr;
        repeat (10) begin
            tick();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_wen", mem_wen, 0);
            chk("idle_ren", mem_ren, 0);
            chk("idle_addr", mem_addr, addr_hold);
        end

        access(0, 1'b1, 32'h20, 32'hCAFEF00D, lat, err, rd, wmask);
        chk("wr20_err", 32'(err), 0);
        chk("wr20_mem", mem[8], 32'hCAFEF00D);

        // Reset mid-ACCESS of a write: enable must drop at once and nothing commits.
        m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h0BADF00D; m0_req = 1'b1;
        tick();
        chk("rstw_wen_pre", mem_wen, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstw_wen_async", mem_wen, 0);
        chk("rstw_busy", 32'(busy), 0);
        m0_req = 1'b0;
        ackcnt = 0;
        repeat (3) begin
            tick();
            if (m0_ack) ackcnt++;
        end
        rst = 1'b1;
        repeat (3) begin
            tick();
            if (m0_ack) ackcnt++;
        end
        $display("txn reset-mid-write acks=%0d mem20=%h", ackcnt, mem[8]);
        chk("rstw_no_ack", ackcnt, 0);
        chk("rstw_mem20", mem[8], 32'hCAFEF00D);
        chk("rstw_idle_busy", 32'(busy), 0);

        // After reset the first tie must go to port 0 even though port 0 won last.
        rr_run(2, 0);
        chk("post_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("post_m1_rdata", m1_rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
